// File: rtl/ascon_pkg.sv
// Shared types, round constants and FSM encoding for the Ascon permutation core.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  localparam logic [3:0] RoundP12  = 4'd0;
  localparam logic [3:0] RoundP6   = 4'd6;
  localparam logic [3:0] LastRound = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } perm_state_e;

  // High nibble counts down while the low nibble counts up: 0xf0, 0xe1, ... 0x4b.
  function automatic logic [63:0] rc(input logic [3:0] r);
    logic [3:0] hi;
    hi = 4'd15 - r;
    return {56'd0, hi, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round (constant add, bitsliced S-box, linear diffusion).
// Latency: purely combinational. Backpressure: none, no state held.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t cur,
  input  logic [3:0]   rnd,
  output ascon_state_t nxt
);

  ascon_state_t p;
  logic [63:0]  t0, t1, t2, t3, t4;

  always_comb begin
    p    = cur;
    p.x2 = p.x2 ^ rc(rnd);

    // S-box applied across all 64 bit-columns at once
    p.x0 = p.x0 ^ p.x4;
    p.x4 = p.x4 ^ p.x3;
    p.x2 = p.x2 ^ p.x1;
    t0   = ~p.x0 & p.x1;
    t1   = ~p.x1 & p.x2;
    t2   = ~p.x2 & p.x3;
    t3   = ~p.x3 & p.x4;
    t4   = ~p.x4 & p.x0;
    p.x0 = p.x0 ^ t1;
    p.x1 = p.x1 ^ t2;
    p.x2 = p.x2 ^ t3;
    p.x3 = p.x3 ^ t4;
    p.x4 = p.x4 ^ t0;
    p.x1 = p.x1 ^ p.x0;
    p.x0 = p.x0 ^ p.x4;
    p.x3 = p.x3 ^ p.x2;
    p.x2 = ~p.x2;

    nxt.x0 = p.x0 ^ ror64(p.x0, 19) ^ ror64(p.x0, 28);
    nxt.x1 = p.x1 ^ ror64(p.x1, 61) ^ ror64(p.x1, 39);
    nxt.x2 = p.x2 ^ ror64(p.x2, 1)  ^ ror64(p.x2, 6);
    nxt.x3 = p.x3 ^ ror64(p.x3, 10) ^ ror64(p.x3, 17);
    nxt.x4 = p.x4 ^ ror64(p.x4, 7)  ^ ror64(p.x4, 41);
  end

endmodule

// File: rtl/ascon_permutation.sv
// Iterated Ascon p12/p6 core; ASCON_PERM_UNROLL2_EN applies two rounds per clock.
// Latency: 12/6 cycles accept-to-valid (6/3 unrolled); one job per N+2 cycles.
// Backpressure: result held in DONE until ready_i; no new job accepted until then.
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int STATE_W = 320,
  parameter int RND_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               sel_p12_i,
  input  logic [STATE_W-1:0] state_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [STATE_W-1:0] state_o,
  output logic [RND_W-1:0]   round_o
);

  if (STATE_W != 320 || RND_W != 4) begin : g_bad_cfg
    $error("ascon_permutation: STATE_W must be 320 and RND_W must be 4");
  end

  perm_state_e      st_q, st_d;
  ascon_state_t     state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  ascon_state_t     rnd_out;
  logic             last_step;
  logic [RND_W-1:0] round_inc;

  ascon_state_t r1;

  ascon_round u_round0 (
    .cur (state_q),
    .rnd (round_q),
    .nxt (r1)
  );

`ifdef ASCON_PERM_UNROLL2_EN
  ascon_state_t     r2;
  logic [RND_W-1:0] round_p1;

  assign round_p1 = round_q + RND_W'(1);

  ascon_round u_round1 (
    .cur (r1),
    .rnd (round_p1),
    .nxt (r2)
  );

  assign rnd_out   = r2;
  assign last_step = (round_p1 == LastRound);
  assign round_inc = round_q + RND_W'(2);
`else
  assign rnd_out   = r1;
  assign last_step = (round_q == LastRound);
  assign round_inc = round_q + RND_W'(1);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    round_d = round_q;
    case (st_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = state_i;
          round_d = sel_p12_i ? RoundP12 : RoundP6;
          st_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = rnd_out;
        if (last_step) begin
          round_d = LastRound;
          st_d    = ST_DONE;
        end else begin
          round_d = round_inc;
        end
      end
      ST_DONE: begin
        if (ready_i) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode FSM state only; reset masks everything immediately.
  assign ready_o = ~rst_i & (st_q == ST_IDLE);
  assign valid_o = ~rst_i & (st_q == ST_DONE);
  assign state_o = rst_i ? '0 : state_q;
  assign round_o = rst_i ? '0 : round_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Scoreboarded bench for ascon_permutation: table-driven S-box reference model,
// latency / round-trace / hold / reset-abort checks; honours ASCON_PERM_UNROLL2_EN.
module tb_ascon_permutation;

`ifdef ASCON_PERM_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic         clk;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic         sel_p12_i;
  logic [319:0] state_i;
  logic         valid_o;
  logic         ready_i;
  logic [319:0] state_o;
  logic [3:0]   round_o;

  int           total;
  int           bad;
  logic [319:0] sb [$];

  ascon_permutation #(.STATE_W(320), .RND_W(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .sel_p12_i (sel_p12_i),
    .state_i   (state_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .state_o   (state_o),
    .round_o   (round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int start);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  v;
    logic [4:0]  o;
    logic [7:0]  c;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int r = start; r < 12; r++) begin
      c = 8'(((15 - r) << 4) | r);
      x[2] = x[2] ^ {56'd0, c};
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[v];
        for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
      end
      x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
      x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
      x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
      x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
      x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job; hold > 0 keeps ready_i low that many cycles in DONE while valid_i is pulsed.
  task automatic run_job(input bit sel, input logic [319:0] st, input int hold);
    int           start;
    int           nc;
    int           k;
    logic [319:0] exp;
    start = sel ? 0 : 6;
    nc    = (12 - start) / STEP;
    ready_i = (hold == 0);
    chk("ready_pre", 320'(ready_o), 320'(1));
    valid_i   = 1'b1;
    sel_p12_i = sel;
    state_i   = st;
    sb.push_back(model_perm(st, start));
    tick();
    valid_i   = 1'b0;
    sel_p12_i = ~sel;
    state_i   = rand320();
    k = 0;
    while (!valid_o && k < 40) begin
      chk("round_trace", 320'(round_o), 320'(start + STEP * k));
      tick();
      k++;
    end
    chk("latency", 320'(k), 320'(nc));
    chk("round_done", 320'(round_o), 320'(11));
    if (valid_o && sb.size() > 0) begin
      exp = sb.pop_front();
      chk("result", state_o, exp);
      for (int i = 0; i < hold; i++) begin
        valid_i   = (i % 2 == 0);
        sel_p12_i = 1'($urandom_range(0, 1));
        state_i   = rand320();
        tick();
        chk("hold_valid", 320'(valid_o), 320'(1));
        chk("hold_state", state_o, exp);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      tick();
      chk("valid_drop", 320'(valid_o), 320'(0));
      chk("ready_back", 320'(ready_o), 320'(1));
    end
  endtask

  initial begin
    int k;
    int vcount;
    total     = 0;
    bad       = 0;
    rst_i     = 1'b1;
    valid_i   = 1'b0;
    sel_p12_i = 1'b0;
    state_i   = '1;
    ready_i   = 1'b1;

    #1;
    chk("rst_ready", 320'(ready_o), 320'(0));
    chk("rst_valid", 320'(valid_o), 320'(0));
    chk("rst_state", state_o, 320'(0));
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("idle_ready", 320'(ready_o), 320'(1));
    chk("idle_valid", 320'(valid_o), 320'(0));
    chk("idle_state", state_o, 320'(0));
    chk("idle_round", 320'(round_o), 320'(0));

    run_job(1'b1, 320'(0), 0);
    run_job(1'b0, rand320(), 0);
    run_job(1'b1, rand320(), 5);

    // Abort a p12 job at round 4 via reset
    valid_i   = 1'b1;
    sel_p12_i = 1'b1;
    state_i   = rand320();
    sb.push_back(model_perm(state_i, 0));
    tick();
    valid_i = 1'b0;
    k = 0;
    while (round_o != 4'd4 && k < 20) begin
      tick();
      k++;
    end
    chk("abort_round", 320'(round_o), 320'(4));
    rst_i = 1'b1;
    sb.delete();
    #1;
    chk("abort_rst_ready", 320'(ready_o), 320'(0));
    chk("abort_rst_valid", 320'(valid_o), 320'(0));
    chk("abort_rst_state", state_o, 320'(0));
    chk("abort_rst_round", 320'(round_o), 320'(0));
    tick();
    rst_i = 1'b0;
    #1;
    chk("abort_idle_ready", 320'(ready_o), 320'(1));
    chk("abort_idle_round", 320'(round_o), 320'(0));
    chk("abort_idle_state", state_o, 320'(0));
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_o) vcount++;
      tick();
    end
    chk("abort_no_valid", 320'(vcount), 320'(0));

    run_job(1'b1, rand320(), 0);
    run_job(1'b0, rand320(), 2);
    run_job(1'b1, {5{64'h0123456789abcdef}}, 0);

    chk("sb_empty", 320'(sb.size()), 320'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
